// File: rtl/imm_gen_stage.sv
// Immediate-generation stage for the rv32i/rv64i decode path: opcode decode, format
// classification and XLEN-wide immediate extension behind a two-entry skid buffer.
module imm_gen_stage #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned TAG_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [31:0]          inst_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [31:0]          inst_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic [XLEN-1:0]      imm_o,
   output logic [2:0]           fmt_o,
   output logic                 illegal_o
);

   localparam logic [6:0] OpLoad    = 7'b0000011;
   localparam logic [6:0] OpMiscMem = 7'b0001111;
   localparam logic [6:0] OpAluI    = 7'b0010011;
   localparam logic [6:0] OpAuipc   = 7'b0010111;
   localparam logic [6:0] OpImm32   = 7'b0011011;
   localparam logic [6:0] OpStore   = 7'b0100011;
   localparam logic [6:0] OpAlu     = 7'b0110011;
   localparam logic [6:0] OpLui     = 7'b0110111;
   localparam logic [6:0] OpAlu32   = 7'b0111011;
   localparam logic [6:0] OpBranch  = 7'b1100011;
   localparam logic [6:0] OpJalr    = 7'b1100111;
   localparam logic [6:0] OpJal     = 7'b1101111;
   localparam logic [6:0] OpSystem  = 7'b1110011;

   localparam logic [2:0] FmtNone = 3'd0;
   localparam logic [2:0] FmtI    = 3'd1;
   localparam logic [2:0] FmtS    = 3'd2;
   localparam logic [2:0] FmtB    = 3'd3;
   localparam logic [2:0] FmtU    = 3'd4;
   localparam logic [2:0] FmtJ    = 3'd5;
   localparam logic [2:0] FmtZ    = 3'd6;

   typedef struct packed {
      logic [31:0]          inst;
      logic [TAG_WIDTH-1:0] tag;
      logic [XLEN-1:0]      imm;
      logic [2:0]           fmt;
      logic                 ill;
   } entry_t;

   logic [31:0] imm32;
   logic [2:0]  fmt_dec;
   logic        ill_dec;
   entry_t      in_entry;

   // Every legal opcode ends in 2'b11, so a bad inst[1:0] falls into the default arm.
   always_comb begin
      imm32   = '0;
      fmt_dec = FmtNone;
      ill_dec = 1'b0;
      case (inst_i[6:0])
         OpLoad, OpMiscMem, OpAluI, OpJalr: begin
            fmt_dec = FmtI;
            imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OpStore: begin
            fmt_dec = FmtS;
            imm32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         OpBranch: begin
            fmt_dec = FmtB;
            imm32   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         end
         OpLui, OpAuipc: begin
            fmt_dec = FmtU;
            imm32   = {inst_i[31:12], 12'b0};
         end
         OpJal: begin
            fmt_dec = FmtJ;
            imm32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                       1'b0};
         end
         OpSystem: begin
            if (inst_i[14]) begin
               fmt_dec = FmtZ;
               imm32   = {27'b0, inst_i[19:15]};
            end else begin
               fmt_dec = FmtI;
               imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
            end
         end
         OpAlu: fmt_dec = FmtNone;
         OpImm32: begin
            if (XLEN == 64) begin
               fmt_dec = FmtI;
               imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
            end else begin
               ill_dec = 1'b1;
            end
         end
         OpAlu32: ill_dec = (XLEN != 64);
         default: ill_dec = 1'b1;
      endcase
   end

   // The zimm value has bit 31 clear, so sign extension doubles as its zero extension.
   always_comb begin
      in_entry      = '0;
      in_entry.inst = inst_i;
      in_entry.tag  = tag_i;
      in_entry.imm  = XLEN'($signed(imm32));
      in_entry.fmt  = fmt_dec;
      in_entry.ill  = ill_dec;
   end

   entry_t main_q, main_d, skid_q, skid_d;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   accept;

   assign in_ready_o = !skid_valid_q;
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready_i) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid_o = main_valid_q;
   assign inst_o      = main_q.inst;
   assign tag_o       = main_q.tag;
   assign imm_o       = main_q.imm;
   assign fmt_o       = main_q.fmt;
   assign illegal_o   = main_q.ill;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the rv32i core's decode path. It accepts a raw instruction word plus a sideband tag over a valid/ready handshake, decodes the opcode, and classifies the instruction format. It produces the sign- or zero-extended immediate at XLEN width behind a 2-entry skid buffer, so fetch-to-decode can run at full throughput with a registered ready. It replaces the combinational sign extension unit, and also adds XLEN=64, CSR zimm, illegal-opcode flagging and pipeline flush.

## Interface
- XLEN, 32, immediate width; legal values 32 and 64
- TAG_WIDTH, 32, width of the opaque sideband (PC) carried alongside each instruction
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  drop all buffered entries and any same-cycle input
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  stage can accept; registered
- inst_i  in  32  instruction word
- tag_i  in  TAG_WIDTH  sideband
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  consumer accepts
- inst_o  out  32  instruction of the output entry
- tag_o  out  TAG_WIDTH  sideband of the output entry
- imm_o  out  XLEN  extended immediate
- fmt_o  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
- illegal_o  out  1  opcode not supported

## Operation
- Decoding uses inst_i[6:0] only. The immediate is computed combinationally on input and registered with the entry.
- LOAD 0000011, MISC_MEM 0001111, ALUI 0010011, JALR 1100111: I format; imm = sext(inst[31:20]).
- STORE 0100011: S format; imm = sext({inst[31:25], inst[11:7]}).
- BRANCH 1100011: B format; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- LUI 0110111, AUIPC 0010111: U format; imm = sext({inst[31:12], 12'b0}). For XLEN=64, bit 31 fills bits 63:32.
- JAL 1101111: J format; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- SYSTEM 1110011:
  - funct3[2]=1: Z format; imm = zext(inst[19:15]).
  - otherwise: I format.
- ALU 0110011: NONE; imm = 0.
- XLEN=64 only: OP_IMM_32 0011011 is I format; OP_32 0111011 is NONE.
- Any other opcode, or inst[1:0] != 2'b11: illegal_o=1, fmt NONE, imm 0. The entry still flows through the stage in order.
- Shift immediates need no special case. Consumers mask the shamt from imm_o.
- Buffer: an output register (main) plus one skid register.
  - in_ready_o = !skid_valid.
  - Accept = in_valid_i & in_ready_o.
  - When main is empty or out_ready_i=1, main loads from skid if skid is valid, else from the accepted input.
  - When main is full and out_ready_i=0, an accepted input goes to skid.
  - Order is strictly FIFO.
- flush_i has priority over all other events. On the next edge main_valid=0 and skid_valid=0. An input handshaking in the flush cycle is discarded. An output handshaking in the flush cycle counts as consumed.

## Timing
- Reset values: out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0, illegal_o=0, inst_o=0, tag_o=0. Skid contents are cleared.
- Reset asserted mid-operation empties the stage immediately (asynchronously); all in-flight entries are lost.
- Latency: an input accepted at edge N is visible on out_valid_o/imm_o after edge N, i.e. in cycle N+1.
- Throughput: 1 entry per cycle while out_ready_i=1.
- Skid full: in_ready_o drops the cycle after the second unconsumed accept. It rises the cycle after skid drains into main.
- Simultaneous out handshake and input accept with skid empty: main is replaced by the new entry, and out_valid_o stays 1.
- Output data is stable while out_valid_o=1 and out_ready_i=0.
- Input signals are don't-care while in_valid_i=0.

## Test plan
- XLEN=32 format sweep, out_ready_i=1. Required imm_o / fmt_o:
  - 0x00500293 -> 0x0000_0005 / I
  - 0x80F80023 -> 0xffff_f800 / S
  - 0xfe4104e3 -> 0xffff_ffe8 / B
  - 0x000170b7 -> 0x0001_7000 / U
  - 0xf19ff26f -> 0xffff_ff18 / J
  - 0x0e80026f -> 0x0000_00e8 / J
  - 0x000AD073 -> 0x0000_0015 / Z
  - Each result appears exactly one cycle after accept.
- XLEN=64:
  - 0xfe4104e3 -> 0xffff_ffff_ffff_ffe8
  - 0x800000b7 -> 0xffff_ffff_8000_0000
  - 0x0050029b -> 5 / I
- Backpressure: hold out_ready_i=0 while pushing 0x00500293, 0x00600313, 0x00700393 with tags 0, 4, 8.
  - Required: first two are accepted, in_ready_o=0 from the third cycle, third word is held off.
  - Release out_ready_i: outputs arrive as imm 5, 6, 7 with tags 0, 4, 8; no loss or duplication.
- Illegal: 0x0000_0000 and 0x0000_0057.
  - Required: illegal_o=1, imm_o=0, fmt_o=0; both entries delivered in order.
- Flush: fill main and skid, then pulse flush_i together with a new input.
  - Required: out_valid_o=0 and in_ready_o=1 the next cycle; the flushed input never appears.
- Reset mid-stream: deassert rst_ni asynchronously between edges with both entries full.
  - Required: out_valid_o=0 immediately, all outputs 0, in_ready_o=1.
  - After release, 0x00500293 yields imm 5 one cycle after accept.
